// File: rtl/debug_mem_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : debug_mem_ctrl_pkg                                           |
// | Description : Debug register map, memory-access FSM encoding and status    |
// |               word bit positions shared by the debug memory controller.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package debug_mem_ctrl_pkg;

  // Debug register block byte offsets
  localparam logic [7:0] c_reg_mem_addr   = 8'h10;
  localparam logic [7:0] c_reg_mem_data   = 8'h14;
  localparam logic [7:0] c_reg_mem_ctrl   = 8'h18;
  localparam logic [7:0] c_reg_mem_status = 8'h1C;
  localparam logic [7:0] c_reg_mem_rdata  = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2
  } dbg_mem_state_e;

  localparam int c_stat_busy          = 0;
  localparam int c_stat_done          = 1;
  localparam int c_stat_timeout_err   = 2;
  localparam int c_stat_bus_err       = 3;
  localparam int c_stat_overflow      = 4;
  localparam int c_stat_last_op_write = 5;
  localparam int c_stat_align_warn    = 6;
  localparam int c_stat_pending_valid = 7;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage : debug_mem_ctrl_pkg
`default_nettype wire

// File: rtl/debug_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : debug_mem_ctrl                                               |
// | Description : Turns debug register write/read pulses into single memory    |
// |               requests, with a 1-deep command queue and response timeout.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module debug_mem_ctrl
  import debug_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] debug_mem_addr,
  input  logic [31:0] debug_mem_data,
  input  logic        debug_mem_write_access,
  input  logic        debug_mem_read_access,
  output logic [31:0] debug_mem_status,
  output logic [31:0] virt_debug_mem_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_rsp_valid,
  input  logic        mem_rsp_err,
  input  logic [31:0] mem_rsp_rdata
);

  localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  dbg_mem_state_e     r_state, w_state_nxt;
  logic               r_req_valid, w_req_valid_nxt;
  logic               r_req_we, w_req_we_nxt;
  logic [31:0]        r_req_addr, w_req_addr_nxt;
  logic [31:0]        r_req_wdata, w_req_wdata_nxt;
  logic               r_pend_valid, w_pend_valid_nxt;
  logic               r_pend_we, w_pend_we_nxt;
  logic [31:0]        r_pend_addr, w_pend_addr_nxt;
  logic [31:0]        r_pend_wdata, w_pend_wdata_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               r_timeout_err, w_timeout_err_nxt;
  logic               r_bus_err, w_bus_err_nxt;
  logic               r_overflow, w_overflow_nxt;
  logic               r_last_op_write, w_last_op_write_nxt;
  logic               r_align_warn, w_align_warn_nxt;
  logic [31:0]        r_rdata, w_rdata_nxt;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;

  logic        w_new_cmd;
  logic        w_capture;
  logic        w_cap_we;
  logic [31:0] w_cap_addr;
  logic [31:0] w_cap_wdata;
  logic [31:0] w_status;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= ST_IDLE;
      r_req_valid     <= 1'b0;
      r_req_we        <= 1'b0;
      r_req_addr      <= 32'h0;
      r_req_wdata     <= 32'h0;
      r_pend_valid    <= 1'b0;
      r_pend_we       <= 1'b0;
      r_pend_addr     <= 32'h0;
      r_pend_wdata    <= 32'h0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_timeout_err   <= 1'b0;
      r_bus_err       <= 1'b0;
      r_overflow      <= 1'b0;
      r_last_op_write <= 1'b0;
      r_align_warn    <= 1'b0;
      r_rdata         <= 32'h0;
      r_cnt           <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_req_valid     <= w_req_valid_nxt;
      r_req_we        <= w_req_we_nxt;
      r_req_addr      <= w_req_addr_nxt;
      r_req_wdata     <= w_req_wdata_nxt;
      r_pend_valid    <= w_pend_valid_nxt;
      r_pend_we       <= w_pend_we_nxt;
      r_pend_addr     <= w_pend_addr_nxt;
      r_pend_wdata    <= w_pend_wdata_nxt;
      r_busy          <= w_busy_nxt;
      r_done          <= w_done_nxt;
      r_timeout_err   <= w_timeout_err_nxt;
      r_bus_err       <= w_bus_err_nxt;
      r_overflow      <= w_overflow_nxt;
      r_last_op_write <= w_last_op_write_nxt;
      r_align_warn    <= w_align_warn_nxt;
      r_rdata         <= w_rdata_nxt;
      r_cnt           <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_req_valid_nxt     = r_req_valid;
    w_req_we_nxt        = r_req_we;
    w_req_addr_nxt      = r_req_addr;
    w_req_wdata_nxt     = r_req_wdata;
    w_pend_valid_nxt    = r_pend_valid;
    w_pend_we_nxt       = r_pend_we;
    w_pend_addr_nxt     = r_pend_addr;
    w_pend_wdata_nxt    = r_pend_wdata;
    w_done_nxt          = r_done;
    w_timeout_err_nxt   = r_timeout_err;
    w_bus_err_nxt       = r_bus_err;
    w_overflow_nxt      = r_overflow;
    w_last_op_write_nxt = r_last_op_write;
    w_align_warn_nxt    = r_align_warn;
    w_rdata_nxt         = r_rdata;
    w_cnt_nxt           = r_cnt;
    w_busy_nxt          = r_busy;
    w_new_cmd           = debug_mem_write_access | debug_mem_read_access;
    w_capture           = 1'b0;
    w_cap_we            = r_pend_we;
    w_cap_addr          = r_pend_addr;
    w_cap_wdata         = r_pend_wdata;

    unique case (r_state)
      ST_IDLE: begin
        if (r_pend_valid) begin
          w_capture        = 1'b1;
          w_pend_valid_nxt = 1'b0;
        end else if (w_new_cmd) begin
          w_capture      = 1'b1;
          w_cap_we       = debug_mem_write_access;
          w_cap_addr     = debug_mem_addr;
          w_cap_wdata    = debug_mem_data;
          w_overflow_nxt = 1'b0;
        end
      end
      ST_REQ: begin
        if (!r_req_valid) begin
          w_req_valid_nxt = 1'b1;
        end else if (mem_req_ready) begin
          w_req_valid_nxt = 1'b0;
          w_cnt_nxt       = '0;
          w_state_nxt     = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (mem_rsp_valid) begin
          w_done_nxt    = 1'b1;
          w_bus_err_nxt = mem_rsp_err;
          if (!r_req_we && !mem_rsp_err) begin
            w_rdata_nxt = mem_rsp_rdata;
          end
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == c_cnt_last) begin
          w_done_nxt        = 1'b1;
          w_timeout_err_nxt = 1'b1;
          w_state_nxt       = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
      end
      default: begin
        w_req_valid_nxt = 1'b0;
        w_state_nxt     = ST_IDLE;
      end
    endcase

    // A pulse that cannot go straight to capture uses the slot; when IDLE is
    // draining the slot this cycle, the slot is free for the new pulse.
    if (w_new_cmd && (r_state != ST_IDLE || r_pend_valid)) begin
      if (!r_pend_valid || r_state == ST_IDLE) begin
        w_pend_valid_nxt = 1'b1;
        w_pend_we_nxt    = debug_mem_write_access;
        w_pend_addr_nxt  = debug_mem_addr;
        w_pend_wdata_nxt = debug_mem_data;
      end else begin
        w_overflow_nxt = 1'b1;
      end
    end

    if (debug_mem_write_access && debug_mem_read_access) begin
      w_overflow_nxt = 1'b1;
    end

    if (w_capture) begin
      w_req_we_nxt        = w_cap_we;
      w_req_addr_nxt      = word_align(w_cap_addr);
      w_req_wdata_nxt     = w_cap_wdata;
      w_done_nxt          = 1'b0;
      w_timeout_err_nxt   = 1'b0;
      w_bus_err_nxt       = 1'b0;
      w_last_op_write_nxt = w_cap_we;
      w_align_warn_nxt    = |w_cap_addr[1:0];
      w_state_nxt         = ST_REQ;
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE) | w_pend_valid_nxt;
  end

  always_comb begin
    w_status                       = 32'h0;
    w_status[c_stat_busy]          = r_busy;
    w_status[c_stat_done]          = r_done;
    w_status[c_stat_timeout_err]   = r_timeout_err;
    w_status[c_stat_bus_err]       = r_bus_err;
    w_status[c_stat_overflow]      = r_overflow;
    w_status[c_stat_last_op_write] = r_last_op_write;
    w_status[c_stat_align_warn]    = r_align_warn;
    w_status[c_stat_pending_valid] = r_pend_valid;
  end

  assign debug_mem_status    = w_status;
  assign virt_debug_mem_data = r_rdata;
  assign mem_req_valid       = r_req_valid;
  assign mem_req_we          = r_req_we;
  assign mem_req_addr        = r_req_addr;
  assign mem_req_wdata       = r_req_wdata;

endmodule : debug_mem_ctrl
`default_nettype wire

// File: tb/tb_debug_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_debug_mem_ctrl                                            |
// | Description : Directed self-checking bench for debug_mem_ctrl.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_debug_mem_ctrl;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] debug_mem_addr;
  logic [31:0] debug_mem_data;
  logic        debug_mem_write_access;
  logic        debug_mem_read_access;
  logic [31:0] debug_mem_status;
  logic [31:0] virt_debug_mem_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic        mem_rsp_err;
  logic [31:0] mem_rsp_rdata;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;

  typedef struct {
    logic        we;
    logic        both;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          delay;
    logic [31:0] exp_addr;
    logic [7:0]  exp_status;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  debug_mem_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk                  (i_clk),
    .i_rst_n                (i_rst_n),
    .debug_mem_addr         (debug_mem_addr),
    .debug_mem_data         (debug_mem_data),
    .debug_mem_write_access (debug_mem_write_access),
    .debug_mem_read_access  (debug_mem_read_access),
    .debug_mem_status       (debug_mem_status),
    .virt_debug_mem_data    (virt_debug_mem_data),
    .mem_req_valid          (mem_req_valid),
    .mem_req_ready          (mem_req_ready),
    .mem_req_we             (mem_req_we),
    .mem_req_addr           (mem_req_addr),
    .mem_req_wdata          (mem_req_wdata),
    .mem_rsp_valid          (mem_rsp_valid),
    .mem_rsp_err            (mem_rsp_err),
    .mem_rsp_rdata          (mem_rsp_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (mem_req_valid && mem_req_ready) hs_count <= hs_count + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual time=%0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic respond(input logic [31:0] rdata, input logic err);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = rdata;
    mem_rsp_err   = err;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
  endtask

  task automatic pulse(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] data);
    debug_mem_write_access = wr;
    debug_mem_read_access  = rd;
    debug_mem_addr         = addr;
    debug_mem_data         = data;
    tick();
    debug_mem_write_access = 1'b0;
    debug_mem_read_access  = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int lat;
    int hs0;
    mem_req_ready = 1'b1;
    hs0 = hs_count;
    pulse(v.we | v.both, !v.we | v.both, v.addr, v.wdata);
    lat = 1;
    while (!mem_req_valid && lat < 8) begin
      tick();
      lat++;
    end
    check("req_latency", 32'(lat), 32'd2);
    check("req_we", 32'(mem_req_we), 32'(v.we));
    check("req_addr", mem_req_addr, v.exp_addr);
    check("req_wdata", mem_req_wdata, v.wdata);
    tick();
    check("busy_in_wait", 32'(debug_mem_status[0]), 32'd1);
    check("valid_drop", 32'(mem_req_valid), 32'd0);
    repeat (v.delay - 1) tick();
    respond(v.rdata, v.err);
    check("txn_status", debug_mem_status, 32'(v.exp_status));
    check("txn_rdata", virt_debug_mem_data, v.exp_data);
    check("txn_one_request", 32'(hs_count - hs0), 32'd1);
  endtask

  initial begin
    vec_t fresh;
    int   n;
    int   hs0;

    vecs[0] = '{1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 3, 32'h100, 8'h22, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h104, 32'h0,        32'hCAFEF00D, 1'b0, 3, 32'h104, 8'h02, 32'hCAFEF00D};
    vecs[2] = '{1'b0, 1'b0, 32'h200, 32'h0,        32'h12345678, 1'b1, 1, 32'h200, 8'h0A, 32'hCAFEF00D};
    vecs[3] = '{1'b1, 1'b0, 32'h300, 32'h11111111, 32'h0,        1'b1, 2, 32'h300, 8'h2A, 32'hCAFEF00D};
    vecs[4] = '{1'b1, 1'b1, 32'h304, 32'h22222222, 32'hFFFFFFFF, 1'b0, 1, 32'h304, 8'h32, 32'hCAFEF00D};
    vecs[5] = '{1'b0, 1'b0, 32'h107, 32'h0,        32'hA5A5A5A5, 1'b0, 4, 32'h104, 8'h42, 32'hA5A5A5A5};

    i_rst_n                = 1'b0;
    debug_mem_addr         = 32'h0;
    debug_mem_data         = 32'h0;
    debug_mem_write_access = 1'b0;
    debug_mem_read_access  = 1'b0;
    mem_req_ready          = 1'b1;
    mem_rsp_valid          = 1'b0;
    mem_rsp_err            = 1'b0;
    mem_rsp_rdata          = 32'h0;
    repeat (2) tick();
    check("rst_status", debug_mem_status, 32'h0);
    check("rst_valid", 32'(mem_req_valid), 32'd0);
    check("rst_addr", mem_req_addr, 32'h0);
    check("rst_rdata", virt_debug_mem_data, 32'h0);
    i_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Synchronous-time reset after the table clears data and flags
    i_rst_n = 1'b0;
    #1;
    check("rst2_status", debug_mem_status, 32'h0);
    check("rst2_rdata", virt_debug_mem_data, 32'h0);
    check("rst2_wdata", mem_req_wdata, 32'h0);
    tick();
    i_rst_n = 1'b1;
    tick();

    // Timeout with a late response
    mem_req_ready = 1'b1;
    pulse(1'b0, 1'b1, 32'h500, 32'h0);
    tick();
    check("to_valid", 32'(mem_req_valid), 32'd1);
    tick();
    repeat (15) tick();
    check("to_not_yet", debug_mem_status, 32'h01);
    tick();
    check("to_status", debug_mem_status, 32'h06);
    respond(32'hBAD0BAD0, 1'b0);
    check("to_late_rdata", virt_debug_mem_data, 32'h0);
    check("to_late_status", debug_mem_status, 32'h06);

    // Back-pressure: payload held while ready is low
    mem_req_ready = 1'b0;
    pulse(1'b1, 1'b0, 32'h400, 32'h55AA55AA);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", 32'(mem_req_valid), 32'd1);
      check("stall_addr", mem_req_addr, 32'h400);
      check("stall_wdata", mem_req_wdata, 32'h55AA55AA);
      tick();
    end
    hs0 = hs_count;
    mem_req_ready = 1'b1;
    tick();
    check("stall_valid_drop", 32'(mem_req_valid), 32'd0);
    repeat (3) tick();
    check("stall_one_xfer", 32'(hs_count - hs0), 32'd1);
    respond(32'h0, 1'b0);
    check("stall_status", debug_mem_status, 32'h22);

    // Three pulses while busy: second queued, third dropped
    hs0 = hs_count;
    pulse(1'b1, 1'b0, 32'h600, 32'h1);
    pulse(1'b1, 1'b0, 32'h604, 32'h2);
    pulse(1'b1, 1'b0, 32'h608, 32'h3);
    check("ovf_status_bits", 32'(debug_mem_status[7:4] & 4'h9), 32'h9);
    check("ovf_busy", 32'(debug_mem_status[0]), 32'd1);
    respond(32'h0, 1'b0);
    n = 0;
    while (!mem_req_valid && n < 10) begin
      tick();
      n++;
    end
    check("ovf_q_seen", 32'(mem_req_valid), 32'd1);
    check("ovf_q_addr", mem_req_addr, 32'h604);
    check("ovf_q_wdata", mem_req_wdata, 32'h2);
    tick();
    respond(32'h0, 1'b0);
    repeat (4) tick();
    check("ovf_req_count", 32'(hs_count - hs0), 32'd2);
    check("ovf_status", debug_mem_status, 32'h32);

    // Fresh capture with an empty slot clears overflow
    fresh = '{1'b1, 1'b0, 32'h700, 32'h77, 32'h0, 1'b0, 1, 32'h700, 8'h22, 32'h0};
    run_txn(fresh);

    // Asynchronous reset while waiting for a response
    pulse(1'b0, 1'b1, 32'h800, 32'h0);
    tick();
    tick();
    check("mr_in_wait", debug_mem_status, 32'h01);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("mr_valid", 32'(mem_req_valid), 32'd0);
    check("mr_status", debug_mem_status, 32'h0);
    check("mr_addr", mem_req_addr, 32'h0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    tick();
    respond(32'h99999999, 1'b0);
    check("mr_late_rdata", virt_debug_mem_data, 32'h0);
    check("mr_late_status", debug_mem_status, 32'h0);
    check("mr_late_valid", 32'(mem_req_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_debug_mem_ctrl
`default_nettype wire
